// File: rtl/punch_pkg.sv
// Shared definitions for the punch judge.
//   state_t  : judge FSM states
//   LED_*    : one-hot lamp pattern per zombie index (index 0 = no target)
//   SCORE_W  : hit counter width
//   led_of() : maps a zombie index to its lamp pattern
package punch_pkg;

  localparam int SCORE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RESULT,
    S_RELEASE
  } state_t;

  localparam logic [3:0] LED_OFF = 4'b0000;
  localparam logic [3:0] LED_Z1  = 4'b0010;
  localparam logic [3:0] LED_Z2  = 4'b0100;
  localparam logic [3:0] LED_Z3  = 4'b1000;

  function automatic logic [3:0] led_of(input logic [1:0] idx);
    case (idx)
      2'd1:    led_of = LED_Z1;
      2'd2:    led_of = LED_Z2;
      2'd3:    led_of = LED_Z3;
      default: led_of = LED_OFF;
    endcase
  endfunction

endpackage

// File: rtl/punch_judge_if.sv
// Target handshake between the target generator (master) and the judge (slave).
//   tgt_valid : generator offers tgt_idx
//   tgt_idx   : zombie index, 1..3 legal, 0 is consumed and dropped
//   tgt_ready : judge can accept a target
interface punch_judge_if;
  logic       tgt_valid;
  logic [1:0] tgt_idx;
  logic       tgt_ready;

  modport master (output tgt_valid, output tgt_idx, input  tgt_ready);
  modport slave  (input  tgt_valid, input  tgt_idx, output tgt_ready);
endinterface

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, debouncer and press detector.
//   clk, rst : system clock, asynchronous active-high reset
//   btn_raw  : raw asynchronous button
//   level    : debounced level; follows the synchronized input only after it
//              has differed for DEBOUNCE_CYCLES consecutive cycles
//   rise     : one-cycle pulse in the first cycle level reads 1
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 625000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the input disagrees with the accepted level;
  // any agreeing cycle restarts the stability interval.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else                                      cnt_d   = cnt_q + 1'b1;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
endmodule

// File: rtl/punch_judge.sv
// Whack-a-zombie judge: accepts a target, lights its lamp, then judges the
// first debounced press (or the window expiry) as a hit or a miss.
//   clk, rst  : system clock, asynchronous active-high reset
//   btn_raw   : raw punch buttons, bit0 = zombie 1 .. bit2 = zombie 3
//   tgt       : target handshake (slave side)
//   led       : one-hot lamp of the armed zombie, 0000 when none
//   hit, miss : one-cycle result pulses (timeout reports as miss)
//   score     : saturating hit count
module punch_judge
  import punch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 625000,
  parameter int WINDOW_CYCLES   = 62500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         btn_raw,
  punch_judge_if.slave       tgt,
  output logic [3:0]         led,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score
);
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [2:0] level, press;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_raw[i]),
      .level   (level[i]),
      .rise    (press[i])
    );
  end

  state_t             state_q;
  logic               tgt_ready_q;
  logic [3:0]         led_q;
  logic               hit_q, miss_q;
  logic [SCORE_W-1:0] score_q;
  logic [WIN_W-1:0]   win_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tgt_ready_q <= 1'b1;
      led_q       <= LED_OFF;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      win_q       <= '0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Index 0 completes the handshake but arms nothing.
          if (tgt.tgt_valid && tgt_ready_q && tgt.tgt_idx != 2'd0) begin
            led_q       <= led_of(tgt.tgt_idx);
            win_q       <= WIN_W'(WINDOW_CYCLES - 1);
            tgt_ready_q <= 1'b0;
            state_q     <= S_ARMED;
          end
        end
        S_ARMED: begin
          // The lamp bits above bit0 double as the expected press vector.
          // A press always wins over an expiring window.
          if (press != 3'b000) begin
            if (press == led_q[3:1]) begin
              hit_q   <= 1'b1;
              score_q <= sat_inc(score_q);
            end else begin
              miss_q <= 1'b1;
            end
            state_q <= S_RESULT;
          end else if (win_q == '0) begin
            miss_q  <= 1'b1;
            state_q <= S_RESULT;
          end else begin
            win_q <= win_q - 1'b1;
          end
        end
        S_RESULT: begin
          led_q   <= LED_OFF;
          state_q <= S_RELEASE;
        end
        S_RELEASE: begin
          // Wait for every button to be up so a held punch cannot be
          // reused against the next target.
          if (level == 3'b000) begin
            tgt_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tgt.tgt_ready = tgt_ready_q;
  assign led           = led_q;
  assign hit           = hit_q;
  assign miss          = miss_q;
  assign score         = score_q;
endmodule

// File: tb/tb_punch_judge.sv
module tb_punch_judge;
  import punch_pkg::*;

  localparam int DB  = 4;
  localparam int WIN = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_raw;
  logic [3:0] led;
  logic       hit, miss;
  logic [7:0] score;

  punch_judge_if tif ();

  punch_judge #(.DEBOUNCE_CYCLES(DB), .WINDOW_CYCLES(WIN)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .tgt     (tif),
    .led     (led),
    .hit     (hit),
    .miss    (miss),
    .score   (score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_hit;
    int score;
    int cyc;   // -1 when arrival time is not pinned
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, results = 0, model_score = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a clean simultaneous press vector p against target idx.
  // No press -> timeout miss; exactly the target's button -> hit; else miss.
  task automatic push_expect(input int idx, input logic [2:0] p, input int c);
    exp_t e;
    logic [2:0] want;
    want = 3'b001 << (idx - 1);
    e.is_hit = (p == want);
    if (e.is_hit && model_score < 255) model_score++;
    e.score = model_score;
    e.cyc   = c;
    q.push_back(e);
  endtask

  // Monitor: every hit/miss pulse is popped against the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (hit || miss)) begin
      results++;
      check("hit_miss_exclusive", int'(hit && miss), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual hit=%0d miss=%0d expected none (cycle %0d)", hit, miss, cyc);
      end else begin
        e = q.pop_front();
        check("result_kind_hit", int'(hit), int'(e.is_hit));
        check("result_score", int'(score), e.score);
        if (e.cyc >= 0) check("result_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm(input int idx, output int c0);
    tif.tgt_valid = 1'b1;
    tif.tgt_idx   = 2'(idx);
    step(1);
    tif.tgt_valid = 1'b0;
    tif.tgt_idx   = 2'd0;
    c0 = cyc;
  endtask

  task automatic wait_results(input int target, input int budget);
    int n;
    n = 0;
    while (results < target && n < budget) begin
      step(1);
      n++;
    end
    if (results < target) check("result_wait", results, target);
  endtask

  task automatic release_all();
    int n;
    btn_raw = 3'b000;
    n = 0;
    while (tif.tgt_ready !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    check("ready_after_release", int'(tif.tgt_ready), 1);
    check("led_idle", int'(led), 0);
  endtask

  task automatic round(input int idx, input logic [2:0] p, input int dly);
    int c0, r0;
    r0 = results;
    arm(idx, c0);
    check("led_armed", int'(led), int'(led_of(2'(idx))));
    check("ready_armed", int'(tif.tgt_ready), 0);
    if (p != 3'b000) begin
      step(dly);
      push_expect(idx, p, -1);
      btn_raw = p;
    end else begin
      push_expect(idx, 3'b000, c0 + WIN);
    end
    wait_results(r0 + 1, 250);
    step(1);
    check("led_cleared", int'(led), 0);
    release_all();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c0, r0, idx, kind;
    logic [2:0] p;

    rst = 1'b1;
    btn_raw = 3'b000;
    tif.tgt_valid = 1'b0;
    tif.tgt_idx = 2'd0;
    step(3);
    check("rst_ready", int'(tif.tgt_ready), 1);
    check("rst_led", int'(led), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_miss", int'(miss), 0);
    check("rst_score", int'(score), 0);
    @(negedge clk) rst = 1'b0;
    step(2);

    // Correct punch, wrong punch, simultaneous punches containing the target.
    round(2, 3'b010, 20);
    check("score_after_hit", int'(score), 1);
    round(3, 3'b001, 10);
    round(1, 3'b011, 5);
    check("score_after_misses", int'(score), 1);

    // Timeout, then a press arriving on the last window cycle.
    round(1, 3'b000, 0);
    r0 = results;
    arm(1, c0);
    step(WIN - 7);
    push_expect(1, 3'b001, c0 + WIN);
    btn_raw = 3'b001;
    wait_results(r0 + 1, 50);
    release_all();

    // Bouncing button: 3-cycle pulses must not register.
    r0 = results;
    arm(1, c0);
    repeat (4) begin
      btn_raw[0] = 1'b1;
      step(3);
      btn_raw[0] = 1'b0;
      step(3);
    end
    check("bounce_no_event", results, r0);
    push_expect(1, 3'b001, -1);
    btn_raw[0] = 1'b1;
    wait_results(r0 + 1, 50);
    release_all();

    // Button held through arming produces nothing until re-pressed.
    btn_raw = 3'b010;
    step(12);
    check("held_idle_ready", int'(tif.tgt_ready), 1);
    r0 = results;
    arm(2, c0);
    step(30);
    check("held_no_event", results, r0);
    btn_raw = 3'b000;
    step(10);
    push_expect(2, 3'b010, -1);
    btn_raw = 3'b010;
    wait_results(r0 + 1, 50);
    release_all();

    // Index 0 handshake is swallowed.
    r0 = results;
    tif.tgt_valid = 1'b1;
    tif.tgt_idx = 2'd0;
    step(1);
    tif.tgt_valid = 1'b0;
    check("idx0_ready", int'(tif.tgt_ready), 1);
    check("idx0_led", int'(led), 0);
    step(5);
    check("idx0_no_result", results, r0);
    check("idx0_ready_later", int'(tif.tgt_ready), 1);

    // Randomized rounds.
    repeat (25) begin
      idx  = $urandom_range(1, 3);
      kind = $urandom_range(0, 3);
      case (kind)
        0, 3:    p = 3'b001 << (idx - 1);
        1:       p = 3'($urandom_range(1, 7));
        default: p = 3'b000;
      endcase
      round(idx, p, $urandom_range(0, 60));
    end

    // Drive the score to saturation and one hit beyond.
    while (model_score < 255) begin
      idx = $urandom_range(1, 3);
      round(idx, 3'b001 << (idx - 1), 0);
    end
    round(3, 3'b100, 2);
    check("score_saturated", int'(score), 255);

    // Reset while armed, with a button held across reset.
    arm(3, c0);
    step(5);
    check("armed_led_z3", int'(led), 4'b1000);
    rst = 1'b1;
    btn_raw = 3'b100;
    #1;
    check("midrst_led", int'(led), 0);
    check("midrst_hit", int'(hit), 0);
    check("midrst_miss", int'(miss), 0);
    check("midrst_score", int'(score), 0);
    check("midrst_ready", int'(tif.tgt_ready), 1);
    model_score = 0;
    step(2);
    r0 = results;
    @(negedge clk) rst = 1'b0;
    step(12);
    check("post_rst_held_ready", int'(tif.tgt_ready), 1);
    check("post_rst_held_no_event", results, r0);
    btn_raw = 3'b000;
    step(10);
    round(3, 3'b100, 4);
    check("score_after_rst_hit", int'(score), 1);

    step(5);
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
